// File: rtl/sdes_ep_xor_stage.sv
// sdes_ep_xor_stage: registered S-DES Fk expansion/permutation + subkey XOR.
// Two-entry elastic buffer (output register O + one skid register S) with a
// registered inReady. The left nibble of the XOR result feeds S0 and the right
// nibble feeds S1. The L/R nibbles and the round tag travel alongside.
// Optional feature: define SDES_EPXOR_PARITY_EN to add outParity, the
// XOR-reduce of {leftSide,rightSide}, held with the payload.
module sdes_ep_xor_stage #(
   parameter int unsigned DEPTH_SKID = 1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       inValid,
   output logic       inReady,
   input  logic [0:7] inData,
   input  logic       inRound,
   input  logic       decryptMode,
   input  logic [0:7] k1,
   input  logic [0:7] k2,
   output logic       outValid,
   input  logic       outReady,
   output logic [0:3] leftSide,
   output logic [0:3] rightSide,
   output logic [0:3] passLeft,
   output logic [0:3] passRight,
   output logic       outRound
`ifdef SDES_EPXOR_PARITY_EN
   ,
   output logic       outParity
`endif
);

`ifdef SDES_EPXOR_PARITY_EN
   localparam int unsigned PW = 18;
`else
   localparam int unsigned PW = 17;
`endif

   // Only a single skid entry is implemented; any other depth must not build.
   generate
      if (DEPTH_SKID != 1) begin : g_bad_depth
         $error("sdes_ep_xor_stage: DEPTH_SKID must be 1");
      end
   endgenerate

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_FULL  = 2'd2
   } state_t;

   state_t        r_state;
   logic          r_out_valid;
   logic          r_in_ready;
   logic [0:PW-1] r_o;
   logic [0:PW-1] r_s;

   logic          w_sel;
   logic [0:7]    w_key;
   logic [0:7]    w_ep;
   logic [0:7]    w_x;
   logic [0:PW-1] w_pay;
   logic          w_accept;
   logic          w_drain;

   // Subkey choice: decryption runs the rounds with the keys swapped.
   assign w_sel = inRound ^ decryptMode;
   assign w_key = w_sel ? k2 : k1;

   // E/P of R = inData[4:7]: {R3,R0,R1,R2,R1,R2,R3,R0}, then subkey XOR.
   assign w_ep = {inData[7], inData[4], inData[5], inData[6],
                  inData[5], inData[6], inData[7], inData[4]};
   assign w_x  = w_ep ^ w_key;

   // Payload layout: XOR result, L/R pass-through, round tag (, parity).
`ifdef SDES_EPXOR_PARITY_EN
   assign w_pay = {w_x, inData, inRound, ^w_x};
`else
   assign w_pay = {w_x, inData, inRound};
`endif

   assign w_accept = inValid && r_in_ready;
   assign w_drain  = r_out_valid && outReady;

   // Occupancy FSM with O/S payload registers; inReady is the next !S.valid.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state     <= ST_EMPTY;
         r_out_valid <= 1'b0;
         r_in_ready  <= 1'b1;
         r_o         <= '0;
         r_s         <= '0;
      end else begin
         case (r_state)
            ST_EMPTY: begin
               if (w_accept) begin
                  r_o         <= w_pay;
                  r_out_valid <= 1'b1;
                  r_state     <= ST_ONE;
               end
            end
            ST_ONE: begin
               if (w_accept && w_drain) begin
                  r_o <= w_pay;
               end else if (w_accept) begin
                  r_s        <= w_pay;
                  r_in_ready <= 1'b0;
                  r_state    <= ST_FULL;
               end else if (w_drain) begin
                  r_out_valid <= 1'b0;
                  r_state     <= ST_EMPTY;
               end
            end
            ST_FULL: begin
               if (w_drain) begin
                  r_o        <= r_s;
                  r_in_ready <= 1'b1;
                  r_state    <= ST_ONE;
               end
            end
            default: begin
               r_state     <= ST_EMPTY;
               r_out_valid <= 1'b0;
               r_in_ready  <= 1'b1;
            end
         endcase
      end
   end

   assign inReady   = r_in_ready;
   assign outValid  = r_out_valid;
   assign leftSide  = r_o[0:3];
   assign rightSide = r_o[4:7];
   assign passLeft  = r_o[8:11];
   assign passRight = r_o[12:15];
   assign outRound  = r_o[16];
`ifdef SDES_EPXOR_PARITY_EN
   assign outParity = r_o[17];
`endif

endmodule
